// File: rtl/uart_rx_framed.sv
// UART receiver with majority-vote sampling, optional parity, error flags and a
// one-entry valid/ready output buffer. LSB-first frames; line idles high.
module uart_rx_framed #(
  parameter int unsigned D_BIT       = 8,
  parameter int unsigned OVERSAMPLE  = 16,
  parameter int unsigned PARITY_MODE = 0,
  parameter int unsigned CNT_W       = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rx_data,
  input  logic             sampling_tick,
  input  logic             dout_ready,
  output logic             dout_valid,
  output logic [D_BIT-1:0] d_out,
  output logic             parity_err,
  output logic             frame_err,
  output logic             overrun_err,
  output logic             break_det,
  output logic             rx_done_tick
);

  localparam logic [CNT_W-1:0] EndBit   = CNT_W'(OVERSAMPLE - 1);
  localparam logic [CNT_W-1:0] EndStart = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [3:0]       LastIdx  = 4'(D_BIT - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop,
    StBrkWait
  } state_e;

  state_e           state_q;
  logic [CNT_W-1:0] tick_cnt_q;
  logic [3:0]       bit_idx_q;
  logic [D_BIT-1:0] data_q;
  logic             samp0_q;
  logic             samp1_q;
  logic             par_bad_q;
  logic             rx_meta;
  logic             rx_s;

  logic [CNT_W-1:0] win_end;
  logic             in_frame;
  logic             at_s0;
  logic             at_s1;
  logic             commit;
  logic             vote;
  logic             par_bad_c;

  // Two-flop synchroniser for the asynchronous serial line.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx_data;
      rx_s    <= rx_meta;
    end
  end

  // Sample-window decode: the start bit is voted at mid-bit, others at full bit.
  always_comb begin
    win_end   = (state_q == StStart) ? EndStart : EndBit;
    in_frame  = (state_q == StStart) || (state_q == StData) ||
                (state_q == StParity) || (state_q == StStop);
    at_s0     = sampling_tick && (tick_cnt_q == win_end - CNT_W'(2));
    at_s1     = sampling_tick && (tick_cnt_q == win_end - CNT_W'(1));
    commit    = in_frame && sampling_tick && (tick_cnt_q == win_end);
    // Third sample is the live rx_s on the commit tick.
    vote      = (samp0_q & samp1_q) | (samp0_q & rx_s) | (samp1_q & rx_s);
    // Even parity: error on odd total; odd parity: error on even total.
    par_bad_c = (^{data_q, vote}) ^ (PARITY_MODE == 1);
  end

  // Frame FSM, sample counters and the output buffer with its flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      tick_cnt_q   <= '0;
      bit_idx_q    <= '0;
      data_q       <= '0;
      samp0_q      <= 1'b0;
      samp1_q      <= 1'b0;
      par_bad_q    <= 1'b0;
      dout_valid   <= 1'b0;
      d_out        <= '0;
      parity_err   <= 1'b0;
      frame_err    <= 1'b0;
      overrun_err  <= 1'b0;
      break_det    <= 1'b0;
      rx_done_tick <= 1'b0;
    end else begin
      rx_done_tick <= 1'b0;
      break_det    <= 1'b0;
      if (dout_valid && dout_ready) dout_valid <= 1'b0;

      if (in_frame && sampling_tick) begin
        tick_cnt_q <= commit ? '0 : tick_cnt_q + CNT_W'(1);
        if (at_s0) samp0_q <= rx_s;
        if (at_s1) samp1_q <= rx_s;
      end

      unique case (state_q)
        StIdle: begin
          if (!rx_s) begin
            state_q    <= StStart;
            tick_cnt_q <= '0;
          end
        end
        StStart: begin
          if (commit) begin
            if (vote) begin
              state_q <= StIdle;
            end else begin
              state_q   <= StData;
              bit_idx_q <= '0;
              par_bad_q <= 1'b0;
            end
          end
        end
        StData: begin
          if (commit) begin
            data_q <= {vote, data_q[D_BIT-1:1]};
            if (bit_idx_q == LastIdx) begin
              state_q <= (PARITY_MODE != 0) ? StParity : StStop;
            end else begin
              bit_idx_q <= bit_idx_q + 4'd1;
            end
          end
        end
        StParity: begin
          if (commit) begin
            par_bad_q <= par_bad_c;
            state_q   <= StStop;
          end
        end
        StStop: begin
          if (commit) begin
            rx_done_tick <= 1'b1;
            break_det    <= (data_q == '0) && !vote;
            // Load when empty or being drained this clk; otherwise drop the frame.
            if (!dout_valid || dout_ready) begin
              dout_valid  <= 1'b1;
              d_out       <= data_q;
              parity_err  <= par_bad_q;
              frame_err   <= !vote;
              overrun_err <= 1'b0;
            end else begin
              overrun_err <= 1'b1;
            end
            // A low stop bit waits for the line to recover before re-arming.
            state_q <= vote ? StIdle : StBrkWait;
          end
        end
        StBrkWait: begin
          if (rx_s) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_framed.sv
// Directed bench for uart_rx_framed: 8N1, even/odd parity and 5-bit/8x instances.
`timescale 1ns/1ps
module tb_uart_rx_framed;

  localparam int TDIV = 4;        // clk cycles per sampling_tick
  localparam int BIT16 = 16 * TDIV;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] tick_ph = 2'd0;
  logic       tick;
  int         cyc = 0;

  logic rx_a, rx_p, rx_c;
  logic ready_a, ready_p, ready_c;

  logic       valid_a, perr_a, ferr_a, oerr_a, brk_a, done_a;
  logic [7:0] dout_a;
  logic       valid_pe, perr_pe, ferr_pe, oerr_pe, brk_pe, done_pe;
  logic [7:0] dout_pe;
  logic       valid_po, perr_po, ferr_po, oerr_po, brk_po, done_po;
  logic [7:0] dout_po;
  logic       valid_c, perr_c, ferr_c, oerr_c, brk_c, done_c;
  logic [4:0] dout_c;

  int vectors = 0;
  int fails = 0;
  int done_a_cnt = 0, brk_a_cnt = 0, vld_a_cnt = 0, vld_a_low_cnt = 0, done_a_cyc = 0;
  int done_pe_cnt = 0, done_po_cnt = 0, done_c_cnt = 0;

  always #5 clk = ~clk;
  always @(posedge clk) begin
    tick_ph <= tick_ph + 2'd1;
    cyc     <= cyc + 1;
  end
  assign tick = (tick_ph == 2'd3);

  uart_rx_framed u_a (
    .clk(clk), .reset(reset), .rx_data(rx_a), .sampling_tick(tick), .dout_ready(ready_a),
    .dout_valid(valid_a), .d_out(dout_a), .parity_err(perr_a), .frame_err(ferr_a),
    .overrun_err(oerr_a), .break_det(brk_a), .rx_done_tick(done_a)
  );

  uart_rx_framed #(.PARITY_MODE(2)) u_pe (
    .clk(clk), .reset(reset), .rx_data(rx_p), .sampling_tick(tick), .dout_ready(ready_p),
    .dout_valid(valid_pe), .d_out(dout_pe), .parity_err(perr_pe), .frame_err(ferr_pe),
    .overrun_err(oerr_pe), .break_det(brk_pe), .rx_done_tick(done_pe)
  );

  uart_rx_framed #(.PARITY_MODE(1)) u_po (
    .clk(clk), .reset(reset), .rx_data(rx_p), .sampling_tick(tick), .dout_ready(ready_p),
    .dout_valid(valid_po), .d_out(dout_po), .parity_err(perr_po), .frame_err(ferr_po),
    .overrun_err(oerr_po), .break_det(brk_po), .rx_done_tick(done_po)
  );

  uart_rx_framed #(.D_BIT(5), .OVERSAMPLE(8), .CNT_W(3)) u_c (
    .clk(clk), .reset(reset), .rx_data(rx_c), .sampling_tick(tick), .dout_ready(ready_c),
    .dout_valid(valid_c), .d_out(dout_c), .parity_err(perr_c), .frame_err(ferr_c),
    .overrun_err(oerr_c), .break_det(brk_c), .rx_done_tick(done_c)
  );

  // Pulse and level counters, sampled mid-cycle.
  always @(negedge clk) begin
    if (done_a) begin
      done_a_cnt <= done_a_cnt + 1;
      done_a_cyc <= cyc;
    end
    if (brk_a) brk_a_cnt <= brk_a_cnt + 1;
    if (valid_a) vld_a_cnt <= vld_a_cnt + 1;
    else vld_a_low_cnt <= vld_a_low_cnt + 1;
    if (done_pe) done_pe_cnt <= done_pe_cnt + 1;
    if (done_po) done_po_cnt <= done_po_cnt + 1;
    if (done_c) done_c_cnt <= done_c_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_line(input int line, input logic v);
    case (line)
      0: rx_a = v;
      1: rx_p = v;
      default: rx_c = v;
    endcase
  endtask

  task automatic hold(input int line, input logic v, input int nclk);
    set_line(line, v);
    repeat (nclk) @(posedge clk);
    #1;
  endtask

  // Start on a fixed tick phase so frame timing is repeatable.
  task automatic align();
    @(posedge clk);
    #1;
    while (tick_ph != 2'd0) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input int line, input logic [8:0] data, input int nd,
                            input bit has_par, input logic par, input logic stop,
                            input int os);
    hold(line, 1'b0, os * TDIV);
    for (int i = 0; i < nd; i++) hold(line, data[i], os * TDIV);
    if (has_par) hold(line, par, os * TDIV);
    hold(line, stop, os * TDIV);
  endtask

  task automatic poke_ready(input int target);
    while (cyc < target) begin
      @(posedge clk);
      #1;
    end
    ready_a = 1'b1;
    @(posedge clk);
    #1;
    ready_a = 1'b0;
  endtask

  int d0, b0, v0, lowc, s1, s2, lat;

  initial begin
    rx_a = 1'b1; rx_p = 1'b1; rx_c = 1'b1;
    ready_a = 1'b1; ready_p = 1'b1; ready_c = 1'b1;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_flags_a", {valid_a, perr_a, ferr_a, oerr_a, brk_a, done_a}, 0);
    check("reset_dout_a", dout_a, 0);
    reset = 1'b0;
    repeat (10) @(posedge clk);
    #1;

    // 8N1 frame 0xA5 with consumer always ready.
    d0 = done_a_cnt; v0 = vld_a_cnt;
    align();
    send_frame(0, 9'h0A5, 8, 0, 1'b0, 1'b1, 16);
    hold(0, 1'b1, BIT16);
    check("a5_dout", dout_a, 32'hA5);
    check("a5_done_pulses", done_a_cnt - d0, 1);
    check("a5_valid_cycles", vld_a_cnt - v0, 1);
    check("a5_flags", {perr_a, ferr_a, oerr_a}, 0);

    // Four-tick low pulse is a false start.
    d0 = done_a_cnt; v0 = vld_a_cnt;
    hold(0, 1'b0, 4 * TDIV);
    hold(0, 1'b1, 2 * BIT16);
    check("false_start_done", done_a_cnt - d0, 0);
    check("false_start_valid", vld_a_cnt - v0, 0);

    // 0x00 with a one-tick high glitch mid data bit 3.
    d0 = done_a_cnt;
    align();
    for (int i = 0; i < 4; i++) hold(0, 1'b0, BIT16);
    hold(0, 1'b0, 7 * TDIV);
    hold(0, 1'b1, TDIV);
    hold(0, 1'b0, 8 * TDIV);
    for (int i = 0; i < 4; i++) hold(0, 1'b0, BIT16);
    hold(0, 1'b1, BIT16);
    hold(0, 1'b1, BIT16);
    check("glitch_dout", dout_a, 0);
    check("glitch_done", done_a_cnt - d0, 1);
    check("glitch_ferr", ferr_a, 0);

    // 0x3C has even weight: parity bit 0 satisfies even, violates odd.
    d0 = done_pe_cnt;
    align();
    send_frame(1, 9'h03C, 8, 1, 1'b0, 1'b1, 16);
    hold(1, 1'b1, BIT16);
    check("par0_even_err", perr_pe, 0);
    check("par0_odd_err", perr_po, 1);
    check("par0_even_dout", dout_pe, 32'h3C);
    send_frame(1, 9'h03C, 8, 1, 1'b1, 1'b1, 16);
    hold(1, 1'b1, BIT16);
    check("par1_even_err", perr_pe, 1);
    check("par1_odd_err", perr_po, 0);
    check("par1_even_dout", dout_pe, 32'h3C);
    check("par1_odd_dout", dout_po, 32'h3C);
    check("par_done_even", done_pe_cnt - d0, 2);
    check("par_done_odd", done_po_cnt - d0, 2);
    check("par_flags_even", {valid_pe, ferr_pe, oerr_pe, brk_pe}, 0);
    check("par_flags_odd", {valid_po, ferr_po, oerr_po, brk_po}, 0);

    // 5 data bits at 8x oversampling.
    d0 = done_c_cnt;
    align();
    send_frame(2, 9'h015, 5, 0, 1'b0, 1'b1, 8);
    hold(2, 1'b1, 8 * TDIV);
    check("d5_dout", dout_c, 32'h15);
    check("d5_done", done_c_cnt - d0, 1);
    check("d5_flags", {valid_c, perr_c, ferr_c, oerr_c, brk_c}, 0);

    // Overrun: second frame dropped while first is held.
    ready_a = 1'b0;
    d0 = done_a_cnt;
    align();
    send_frame(0, 9'h011, 8, 0, 1'b0, 1'b1, 16);
    send_frame(0, 9'h022, 8, 0, 1'b0, 1'b1, 16);
    hold(0, 1'b1, BIT16);
    check("ovr_dout", dout_a, 32'h11);
    check("ovr_flag", oerr_a, 1);
    check("ovr_valid", valid_a, 1);
    check("ovr_done", done_a_cnt - d0, 2);
    ready_a = 1'b1;
    @(posedge clk);
    #1;
    ready_a = 1'b0;
    check("ovr_consumed_valid", valid_a, 0);
    check("ovr_consumed_dout", dout_a, 32'h11);

    // Consume in the very clk the next frame ends: reload without a gap.
    align();
    s1 = cyc;
    send_frame(0, 9'h011, 8, 0, 1'b0, 1'b1, 16);
    lat = done_a_cyc - s1;
    hold(0, 1'b1, BIT16);
    check("sim_first_valid", valid_a, 1);
    check("sim_first_oerr", oerr_a, 0);
    lowc = vld_a_low_cnt;
    d0 = done_a_cnt;
    align();
    s2 = cyc;
    fork
      send_frame(0, 9'h022, 8, 0, 1'b0, 1'b1, 16);
      poke_ready(s2 + lat - 1);
    join
    check("sim_dout", dout_a, 32'h22);
    check("sim_oerr", oerr_a, 0);
    check("sim_valid", valid_a, 1);
    check("sim_no_gap", vld_a_low_cnt - lowc, 0);
    check("sim_done", done_a_cnt - d0, 1);
    ready_a = 1'b1;
    @(posedge clk);
    #1;

    // Line held low for three frame times: one break frame only.
    d0 = done_a_cnt; b0 = brk_a_cnt;
    align();
    hold(0, 1'b0, 3 * 10 * BIT16);
    hold(0, 1'b1, 2 * BIT16);
    check("brk_done", done_a_cnt - d0, 1);
    check("brk_pulse", brk_a_cnt - b0, 1);
    check("brk_dout", dout_a, 0);
    check("brk_ferr", ferr_a, 1);
    check("brk_perr", perr_a, 0);

    // Reset in the middle of data bits, then a clean 0x5A.
    ready_a = 1'b0;
    align();
    send_frame(0, 9'h0C3, 8, 0, 1'b0, 1'b1, 16);
    hold(0, 1'b1, BIT16);
    check("pre_rst_dout", dout_a, 32'hC3);
    d0 = done_a_cnt;
    align();
    hold(0, 1'b0, BIT16);
    hold(0, 1'b0, BIT16);
    hold(0, 1'b1, BIT16);
    hold(0, 1'b0, BIT16);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("rst_flags", {valid_a, perr_a, ferr_a, oerr_a, brk_a, done_a}, 0);
    check("rst_dout", dout_a, 0);
    reset = 1'b0;
    hold(0, 1'b1, 2 * BIT16);
    check("rst_no_done", done_a_cnt - d0, 0);
    ready_a = 1'b1;
    d0 = done_a_cnt;
    align();
    send_frame(0, 9'h05A, 8, 0, 1'b0, 1'b1, 16);
    hold(0, 1'b1, BIT16);
    check("post_rst_dout", dout_a, 32'h5A);
    check("post_rst_done", done_a_cnt - d0, 1);
    check("post_rst_flags", {perr_a, ferr_a, oerr_a}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule

// File: doc/uart_rx_framed.md
Name: uart_rx_framed

Overview:
- Parametrised UART receiver for the host-to-accelerator link. It carries MNIST pixel and weight bytes from the PC into the network loader.
- Generalises the fixed 8N1 receiver:
  - configurable data width, oversampling ratio and parity;
  - 2-flop input synchroniser and 3-sample majority-vote bit decisions;
  - false-start rejection;
  - parity, framing, overrun and break detection;
  - one-entry valid/ready output buffer.
- Sits between the baud tick generator (clock_frequency_divider) and the byte consumer.

Parameters:
- D_BIT, 8, data bits per frame; legal 5..9; LSB received first.
- OVERSAMPLE, 16, sampling_tick pulses per bit period; legal even values 8..32.
- PARITY_MODE, 0, 0 = none, 1 = odd, 2 = even.
- CNT_W, 5, tick counter width; must satisfy 2^CNT_W >= OVERSAMPLE.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- rx_data  in  1  serial line, asynchronous to clk, idle high.
- sampling_tick  in  1  one-clk pulse at OVERSAMPLE x baud.
- dout_ready  in  1  consumer accepts the buffered word.
- dout_valid  out  1  buffer holds an unconsumed word.
- d_out  out  D_BIT  received data, bit 0 = first data bit on the line.
- parity_err  out  1  buffered word failed parity; always 0 when PARITY_MODE = 0.
- frame_err  out  1  buffered word had stop bit decided 0.
- overrun_err  out  1  at least one frame was dropped while this word was held.
- break_det  out  1  one-clk pulse: all data bits 0 and stop bit 0.
- rx_done_tick  out  1  one-clk pulse at the end of every frame, including dropped frames.

Behaviour:
- Clock and reset:
  - One clock domain (clk). Reset is synchronous and active-high (reset).
  - Reset values: all outputs 0; synchroniser flops 1; FSM in IDLE; counters 0.
  - Reset asserted mid-frame abandons the frame. No rx_done_tick and no buffer write result from it.
- Input path:
  - rx_data passes through 2 flops to give rx_s. All decisions use rx_s.
  - Input-to-detection latency is 2 clk.
- Tick counter:
  - tick_cnt increments only on cycles with sampling_tick = 1.
  - Per-bit window end is E = OVERSAMPLE-1; start window end is H = OVERSAMPLE/2-1.
- Majority vote:
  - Samples are taken on the ticks where tick_cnt = end-2, end-1 and end.
  - Bit value = majority of the 3 samples. It is committed on the tick where tick_cnt = end, and tick_cnt is then reset to 0.
- FSM states and transitions:
  - IDLE: when rx_s = 0, go to START with tick_cnt = 0. No tick is needed to leave IDLE.
  - START: vote window ends at H.
    - Vote = 1: false start; return to IDLE with no outputs.
    - Vote = 0: go to DATA with bit index 0.
  - DATA: one vote per bit, window end E. Shift the bit right into the shift register, LSB first. After bit D_BIT-1, go to PARITY if PARITY_MODE != 0, otherwise go to STOP.
  - PARITY: one vote, window end E.
    - Even mode: error when XOR of the data bits and the parity bit = 1.
    - Odd mode: error when that XOR = 0.
  - STOP: one vote, window end E. This is the frame end; apply the "frame end" rules below, then:
    - stop = 1: go to IDLE;
    - stop = 0: go to BRK_WAIT.
  - BRK_WAIT: stay until rx_s = 1, then go to IDLE. This prevents a held-low line from producing repeated frames.
  - Only the first stop bit is checked. A following start edge is accepted in IDLE immediately after STOP.
- Frame end (same clk as the STOP commit):
  - rx_done_tick = 1 for exactly 1 clk.
  - frame_err candidate = !stop.
  - break_det = 1 for 1 clk if data == 0 and stop == 0.
- Output buffer:
  - Handshake: a word transfers on a clk where dout_valid && dout_ready. On that clk dout_valid drops, unless a new word is loaded in the same clk.
  - Loading: the buffer loads at frame end if it is empty, or if it is being consumed in the same clk. A load sets d_out, parity_err, frame_err, dout_valid = 1 and overrun_err = 0.
  - Drop: if the buffer is full and not consumed at frame end, the new frame is discarded. The held word's d_out and error flags are unchanged, and overrun_err is set to 1.
  - d_out and the flags are stable while dout_valid = 1. After consumption they hold their last value.
  - Errored frames (parity, framing, break) are still delivered, with their flags set.
- Tick behaviour: sampling_tick = 1 on every clk is legal. With sampling_tick stuck at 0, the FSM stalls in its current state, except that IDLE still leaves on rx_s = 0.

Test Plan:
- Defaults (8N1, OVERSAMPLE 16). Send 0xA5 with dout_ready held 1 -> d_out = 0xA5, dout_valid high 1 clk, rx_done_tick 1 pulse, all error flags 0.
- PARITY_MODE = 2. Send 0x3C with parity bit 0 -> parity_err = 0. Send 0x3C with parity bit 1 -> parity_err = 1, d_out = 0x3C. Repeat with PARITY_MODE = 1 -> results inverted.
- Glitch tests:
  - Low pulse of 4 ticks on an idle line -> FSM returns to IDLE; no rx_done_tick; dout_valid stays 0.
  - A single-tick high glitch at the centre of data bit 3 of 0x00 -> d_out = 0x00, because the majority vote rejects it.
- Overrun: dout_ready = 0; send 0x11 then 0x22 -> d_out = 0x11, overrun_err = 1, two rx_done_tick pulses. Then raise dout_ready for 1 clk -> dout_valid = 0.
- Simultaneous events:
  - Assert dout_ready exactly in the frame-end clk of a second frame -> d_out = 0x22, overrun_err = 0, dout_valid stays 1.
  - Separately, hold rx_data low for 3 frame times -> one frame with d_out = 0x00, frame_err = 1 and break_det pulse. No further frames until the line returns high.
- Reset and D_BIT:
  - Assert reset mid-DATA -> all outputs 0 next clk. A following 0x5A frame is received correctly.
  - With D_BIT = 5 and OVERSAMPLE = 8, send 0x15 -> d_out = 5'h15.
